// File: rtl/ram_pkg.sv
// Shared definitions for the RAM family: clear-engine state encoding and
// helpers that derive lane count and address width from the parameters.
// Latency: n/a (types and constant functions only). Backpressure: n/a.
package ram_pkg;

    typedef enum logic {
        CLR_IDLE   = 1'b0,
        CLR_ACTIVE = 1'b1
    } clr_state_e;

    // Number of byte-enable lanes in a data word.
    function automatic int calc_nb(input int width, input int byte_w);
        return width / byte_w;
    endfunction

    // Address width; a single-word array still gets a 1-bit address.
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Elaboration-time sanity check used by every RAM top: the word must
    // split into whole lanes.
    function automatic bit width_ok(input int width, input int byte_w);
        return (byte_w > 0) && ((width % byte_w) == 0);
    endfunction

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear engine: walks every word once, issuing a zero-write strobe per cycle.
// Latency: busy the cycle after rst/clr_req, for exactly DEPTH cycles.
// Backpressure: none; clr_req while busy is ignored, rst restarts from word 0.
//
// Ports: clk, rst (async, active high), clr_req (start pulse),
//        clr_busy (engine active), clr_we / clr_addr (zero-write strobe/address).
module ram_clr_fsm
    import ram_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_e    state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLR_ACTIVE;
            cnt   <= '0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (clr_req) begin
                        state <= CLR_ACTIVE;
                        cnt   <= '0;
                    end
                end
                CLR_ACTIVE: begin
                    // The word at LAST is written this cycle; leave next cycle.
                    if (cnt == LAST) begin
                        state <= CLR_IDLE;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: begin
                    state <= CLR_ACTIVE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign clr_busy = (state == CLR_ACTIVE);
    assign clr_we   = clr_busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/sdpram_be.sv
// Simple-dual-port RAM with per-lane write enables and a built-in clear engine.
// Latency: read 1 cycle (SYNC_READ=1) or combinational (SYNC_READ=0).
// Backpressure: none; while clr_busy, writes are dropped and reads not accepted.
//
// Ports: clk, rst (async, active high); clr_req/clr_busy start and track a
//        full-array zero fill; wr_en/wr_addr/wr_data/wr_be write port;
//        rd_en/rd_addr read request, rd_data/rd_valid read result.
// Option: define SDPRAM_FWD_EN for write-first (per-lane) forwarding on a
//         same-cycle same-address read/write; otherwise reads return old data.
module sdpram_be
    import ram_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 64,
    parameter int BYTE_W    = 8,
    parameter int SYNC_READ = 1,
    localparam int NB       = calc_nb(WIDTH, BYTE_W),
    localparam int AW       = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    output logic             clr_busy,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [NB-1:0]    wr_be,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    if (!width_ok(WIDTH, BYTE_W)) begin : g_width_check
        $error("sdpram_be: WIDTH must be a non-zero multiple of BYTE_W");
    end

    // DEPTH need not be a power of two, so range checks compare against it
    // with one extra bit of headroom.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             wr_ok;
    logic             rd_ok;
    logic             rd_in_range;
    logic [WIDTH-1:0] stored_word;
    logic [WIDTH-1:0] rd_word;

    logic [WIDTH-1:0] mem [DEPTH];

    ram_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_ok       = wr_en & ~clr_busy & ({1'b0, wr_addr} < DEPTH_W);
    assign rd_ok       = rd_en & ~clr_busy;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    // Array has no reset; the clear engine owns it while busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) begin
                    mem[wr_addr][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign stored_word = rd_in_range ? mem[rd_addr] : '0;

`ifdef SDPRAM_FWD_EN
    // Write-first per lane: lanes being written this cycle bypass the array.
    always_comb begin
        rd_word = stored_word;
        for (int k = 0; k < NB; k++) begin
            if (wr_ok && (wr_addr == rd_addr) && wr_be[k]) begin
                rd_word[k*BYTE_W +: BYTE_W] = wr_data[k*BYTE_W +: BYTE_W];
            end
        end
    end
`else
    assign rd_word = stored_word;
`endif

    if (SYNC_READ != 0) begin : g_sync_read
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        // rd_data holds the last accepted result until the next accepted read.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_ok;
                if (rd_ok) begin
                    rd_data_q <= rd_word;
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_comb_read
        assign rd_data  = rd_ok ? rd_word : '0;
        assign rd_valid = rd_ok;
    end

endmodule

// File: tb/tb_sdpram_be.sv
module tb_sdpram_be;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Instance s: DEPTH=64, registered read. Instance c: DEPTH=48, combinational read.
    logic        s_clr_req, s_clr_busy, s_wr_en, s_rd_en, s_rd_valid;
    logic [5:0]  s_wr_addr, s_rd_addr;
    logic [63:0] s_wr_data, s_rd_data;
    logic [7:0]  s_wr_be;

    logic        c_clr_req, c_clr_busy, c_wr_en, c_rd_en, c_rd_valid;
    logic [5:0]  c_wr_addr, c_rd_addr;
    logic [63:0] c_wr_data, c_rd_data;
    logic [7:0]  c_wr_be;

    int checks = 0;
    int errors = 0;

    sdpram_be #(.WIDTH(64), .DEPTH(64), .BYTE_W(8), .SYNC_READ(1)) u_sync (
        .clk(clk), .rst(rst), .clr_req(s_clr_req), .clr_busy(s_clr_busy),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_be(s_wr_be),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid)
    );

    sdpram_be #(.WIDTH(64), .DEPTH(48), .BYTE_W(8), .SYNC_READ(0)) u_comb (
        .clk(clk), .rst(rst), .clr_req(c_clr_req), .clr_busy(c_clr_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .wr_be(c_wr_be),
        .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid)
    );

    function automatic logic [63:0] fill(input int a);
        return {16'hA5A5, 16'(a), 16'h5A5A, 16'(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic s_write(input logic [5:0] a, input logic [63:0] d, input logic [7:0] be);
        s_wr_en = 1'b1; s_wr_addr = a; s_wr_data = d; s_wr_be = be;
        step();
        s_wr_en = 1'b0;
    endtask

    task automatic s_read(input logic [5:0] a);
        s_rd_en = 1'b1; s_rd_addr = a;
        step();
        s_rd_en = 1'b0;
    endtask

    task automatic c_write(input logic [5:0] a, input logic [63:0] d, input logic [7:0] be);
        c_wr_en = 1'b1; c_wr_addr = a; c_wr_data = d; c_wr_be = be;
        step();
        c_wr_en = 1'b0;
    endtask

    // Number of clock edges after the current point until each clr_busy falls.
    task automatic measure_clear(output int s_fall, output int c_fall);
        s_fall = 0;
        c_fall = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (!s_clr_busy && s_fall == 0) s_fall = i;
            if (!c_clr_busy && c_fall == 0) c_fall = i;
            if (s_fall != 0 && c_fall != 0) break;
        end
    endtask

    task automatic test_reset();
        int s_fall, c_fall;
        rst = 1'b1;
        #1;
        checks++; if (s_clr_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", s_clr_busy); end
        checks++; if (s_rd_valid !== 1'b0 || s_rd_data !== 64'h0) begin errors++; $display("FAIL reset_sync_rd: valid %b data %h want 0/0", s_rd_valid, s_rd_data); end
        checks++; if (c_rd_valid !== 1'b0 || c_rd_data !== 64'h0) begin errors++; $display("FAIL reset_comb_rd: valid %b data %h want 0/0", c_rd_valid, c_rd_data); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        measure_clear(s_fall, c_fall);
        checks++; if (s_fall != 64) begin errors++; $display("FAIL reset_clear_len64: got %0d want 64", s_fall); end
        checks++; if (c_fall != 48) begin errors++; $display("FAIL reset_clear_len48: got %0d want 48", c_fall); end
        // Back-to-back reads of every word: each result one cycle after its rd_en.
        s_rd_en = 1'b1;
        for (int a = 0; a < 64; a++) begin
            s_rd_addr = 6'(a);
            step();
            checks++;
            if (s_rd_valid !== 1'b1 || s_rd_data !== 64'h0) begin
                errors++; $display("FAIL reset_read_zero[%0d]: valid %b data %h want 1/0", a, s_rd_valid, s_rd_data);
            end
        end
        s_rd_en = 1'b0;
        step();
        checks++; if (s_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b want 0", s_rd_valid); end
        c_rd_en = 1'b1;
        for (int a = 0; a < 48; a++) begin
            c_rd_addr = 6'(a);
            #1;
            checks++;
            if (c_rd_valid !== 1'b1 || c_rd_data !== 64'h0) begin
                errors++; $display("FAIL reset_comb_zero[%0d]: valid %b data %h want 1/0", a, c_rd_valid, c_rd_data);
            end
        end
        c_rd_en = 1'b0;
    endtask

    task automatic test_byte_enable();
        s_write(6'd5, 64'h1111_1111_1111_1111, 8'hFF);
        s_write(6'd5, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
        s_read(6'd5);
        checks++; if (s_rd_data !== 64'h1111_1111_CAFE_F00D) begin errors++; $display("FAIL be_low: got %h want 11111111cafef00d", s_rd_data); end
        s_write(6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        s_read(6'd5);
        checks++; if (s_rd_data !== 64'h1111_1111_CAFE_F00D) begin errors++; $display("FAIL be_zero_noop: got %h want 11111111cafef00d", s_rd_data); end
        s_write(6'd5, 64'hDEAD_BEEF_0000_0000, 8'hF0);
        s_read(6'd5);
        checks++; if (s_rd_data !== 64'hDEAD_BEEF_CAFE_F00D) begin errors++; $display("FAIL be_high: got %h want deadbeefcafef00d", s_rd_data); end
    endtask

    task automatic test_same_addr();
        logic [63:0] exp_s, exp_c;
`ifdef SDPRAM_FWD_EN
        exp_s = 64'hAAAA_AAAA_AAAA_AAAA;
        exp_c = 64'h0123_4567_FFFF_FFFF;
`else
        exp_s = 64'h5555_5555_5555_5555;
        exp_c = 64'h0123_4567_89AB_CDEF;
`endif
        s_write(6'd9, 64'h5555_5555_5555_5555, 8'hFF);
        s_wr_en = 1'b1; s_wr_addr = 6'd9; s_wr_data = 64'hAAAA_AAAA_AAAA_AAAA; s_wr_be = 8'hFF;
        s_rd_en = 1'b1; s_rd_addr = 6'd9;
        step();
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        checks++; if (s_rd_valid !== 1'b1 || s_rd_data !== exp_s) begin errors++; $display("FAIL same_addr_sync: valid %b data %h want 1/%h", s_rd_valid, s_rd_data, exp_s); end
        s_read(6'd9);
        checks++; if (s_rd_data !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("FAIL same_addr_after: got %h want aa..aa", s_rd_data); end
        // Partial-lane collision on the combinational instance.
        c_write(6'd3, 64'h0123_4567_89AB_CDEF, 8'hFF);
        c_wr_en = 1'b1; c_wr_addr = 6'd3; c_wr_data = 64'hFFFF_FFFF_FFFF_FFFF; c_wr_be = 8'h0F;
        c_rd_en = 1'b1; c_rd_addr = 6'd3;
        #1;
        checks++; if (c_rd_data !== exp_c) begin errors++; $display("FAIL same_addr_comb: got %h want %h", c_rd_data, exp_c); end
        step();
        c_wr_en = 1'b0;
        #1;
        checks++; if (c_rd_data !== 64'h0123_4567_FFFF_FFFF) begin errors++; $display("FAIL same_addr_comb_after: got %h want 01234567ffffffff", c_rd_data); end
        c_rd_en = 1'b0;
    endtask

    task automatic test_clear();
        int n;
        int bad_valid;
        for (int a = 0; a < 64; a++) s_write(6'(a), fill(a), 8'hFF);
        s_read(6'd3);
        checks++; if (s_rd_data !== fill(3)) begin errors++; $display("FAIL fill_read: got %h want %h", s_rd_data, fill(3)); end
        s_clr_req = 1'b1;
        step();
        s_clr_req = 1'b0;
        checks++; if (s_clr_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_rise: got %b want 1", s_clr_busy); end
        s_wr_en = 1'b1; s_wr_addr = 6'd7; s_wr_data = 64'hFFFF_FFFF_FFFF_FFFF; s_wr_be = 8'hFF;
        s_rd_en = 1'b1; s_rd_addr = 6'd7;
        n = 0;
        bad_valid = 0;
        while (s_clr_busy && n < 200) begin
            s_clr_req = (n == 10);
            step();
            n++;
            if (s_rd_valid !== 1'b0) bad_valid++;
        end
        s_clr_req = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0;
        checks++; if (n != 64) begin errors++; $display("FAIL clr_len: got %0d want 64", n); end
        checks++; if (bad_valid != 0) begin errors++; $display("FAIL clr_rd_valid: got %0d valid cycles want 0", bad_valid); end
        checks++; if (s_rd_data !== fill(3)) begin errors++; $display("FAIL clr_rd_hold: got %h want %h", s_rd_data, fill(3)); end
        s_rd_en = 1'b1;
        for (int a = 0; a < 64; a++) begin
            s_rd_addr = 6'(a);
            step();
            checks++;
            if (s_rd_valid !== 1'b1 || s_rd_data !== 64'h0) begin
                errors++; $display("FAIL clr_zero[%0d]: valid %b data %h want 1/0", a, s_rd_valid, s_rd_data);
            end
        end
        s_rd_en = 1'b0;
        step();
    endtask

    task automatic test_comb_range();
        c_write(6'd50, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        c_rd_en = 1'b1; c_rd_addr = 6'd50;
        #1;
        checks++; if (c_rd_valid !== 1'b1 || c_rd_data !== 64'h0) begin errors++; $display("FAIL oor_read50: valid %b data %h want 1/0", c_rd_valid, c_rd_data); end
        c_rd_addr = 6'd48;
        #1;
        checks++; if (c_rd_valid !== 1'b1 || c_rd_data !== 64'h0) begin errors++; $display("FAIL oor_read48: valid %b data %h want 1/0", c_rd_valid, c_rd_data); end
        c_rd_addr = 6'd2;
        #1;
        checks++; if (c_rd_data !== 64'h0) begin errors++; $display("FAIL oor_no_alias: got %h want 0", c_rd_data); end
        c_rd_en = 1'b0;
        c_write(6'd47, 64'hFEED_FACE_0BAD_C0DE, 8'hFF);
        c_rd_en = 1'b1; c_rd_addr = 6'd47;
        #1;
        checks++; if (c_rd_valid !== 1'b1 || c_rd_data !== 64'hFEED_FACE_0BAD_C0DE) begin errors++; $display("FAIL comb_last: valid %b data %h want 1/feedface0badc0de", c_rd_valid, c_rd_data); end
        c_rd_en = 1'b0;
        #1;
        checks++; if (c_rd_valid !== 1'b0 || c_rd_data !== 64'h0) begin errors++; $display("FAIL comb_idle: valid %b data %h want 0/0", c_rd_valid, c_rd_data); end
    endtask

    task automatic test_reset_mid_clear();
        int s_fall, c_fall;
        s_write(6'd1, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF);
        s_read(6'd1);
        checks++; if (s_rd_data !== 64'h0F0F_0F0F_0F0F_0F0F) begin errors++; $display("FAIL mid_pre_read: got %h want 0f0f0f0f0f0f0f0f", s_rd_data); end
        s_clr_req = 1'b1; c_clr_req = 1'b1;
        step();
        s_clr_req = 1'b0; c_clr_req = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        #1;
        checks++; if (s_rd_valid !== 1'b0 || s_rd_data !== 64'h0) begin errors++; $display("FAIL mid_rst_rd: valid %b data %h want 0/0", s_rd_valid, s_rd_data); end
        checks++; if (s_clr_busy !== 1'b1 || c_clr_busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy: s %b c %b want 1/1", s_clr_busy, c_clr_busy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        measure_clear(s_fall, c_fall);
        checks++; if (s_fall != 64) begin errors++; $display("FAIL mid_clear_len64: got %0d want 64", s_fall); end
        checks++; if (c_fall != 48) begin errors++; $display("FAIL mid_clear_len48: got %0d want 48", c_fall); end
        s_read(6'd1);
        checks++; if (s_rd_valid !== 1'b1 || s_rd_data !== 64'h0) begin errors++; $display("FAIL mid_post_read: valid %b data %h want 1/0", s_rd_valid, s_rd_data); end
    endtask

    initial begin
        s_clr_req = 1'b0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_wr_be = '0;
        s_rd_en = 1'b0; s_rd_addr = '0;
        c_clr_req = 1'b0; c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_wr_be = '0;
        c_rd_en = 1'b0; c_rd_addr = '0;
        #1;
        test_reset();
        test_byte_enable();
        test_same_addr();
        test_clear();
        test_comb_range();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdpram_be.md
# sdpram_be

Parametrised simple-dual-port RAM: one write port with per-byte write enables, one independent read port, and a selectable combinational or registered read path. A built-in clear engine zeroes the array after reset or on request, one word per cycle, so the array itself needs no reset fan-out. It is the generic storage primitive for register files, predictor tables and small queues where a write and a read to different or equal addresses occur in the same cycle.

## Interface
- WIDTH, 64, data word width in bits; must be a multiple of BYTE_W
- DEPTH, 64, number of words; need not be a power of two
- BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W lanes
- SYNC_READ, 1, 1 = registered read (1-cycle latency), 0 = combinational read
- clk  in  1  clock, posedge
- rst  in  1  reset, asynchronous, active high
- clr_req  in  1  pulse: start a full-array clear when idle
- clr_busy  out  1  clear engine active; port accesses blocked
- wr_en  in  1  write strobe
- wr_addr  in  AW=$clog2(DEPTH)  write address
- wr_data  in  WIDTH  write data
- wr_be  in  NB  byte-lane write enables; lane k covers bits [k*BYTE_W +: BYTE_W]
- rd_en  in  1  read strobe
- rd_addr  in  AW  read address
- rd_data  out  WIDTH  read data
- rd_valid  out  1  rd_data carries the result of an accepted read

## Operation
- Clear FSM states: IDLE, CLEAR. rst (async) forces CLEAR, clear counter = 0, rd_data = 0, rd_valid = 0.
- CLEAR: each cycle writes all-zero to mem[counter], counter +1; at counter = DEPTH-1 the last word is written and the FSM moves to IDLE next cycle. Total DEPTH cycles. clr_busy = (state == CLEAR).
- IDLE + clr_req: enter CLEAR next cycle, counter = 0. clr_req during CLEAR ignored (no restart).
- Writes: accepted when wr_en & ~clr_busy & wr_addr < DEPTH; only lanes with wr_be[k]=1 change. wr_be = 0 is a no-op. Writes during CLEAR are dropped.
- Reads: accepted when rd_en & ~clr_busy. Out-of-range rd_addr (>= DEPTH) returns 0 with rd_valid asserted.
- Read during CLEAR: not accepted; rd_valid low, rd_data 0 (SYNC_READ=0) or held (SYNC_READ=1).
- Same-cycle read and write to same address: see Configuration.
- rst mid-clear restarts the clear from word 0.

## Timing
- SYNC_READ=1: accepted read at cycle N → rd_data and rd_valid at cycle N+1; rd_valid is a 1-cycle pulse per accepted read; rd_data holds its value when no read is accepted.
- SYNC_READ=0: rd_data = mem[rd_addr] combinationally when accepted, else 0; rd_valid = accepted, combinational.
- Write at edge N is visible to a read accepted in cycle N+1 in both modes.
- clr_busy rises the cycle after clr_req is sampled in IDLE and falls exactly DEPTH cycles later; after rst deassertion it falls DEPTH cycles after the first clock edge.

## Configuration
- SDPRAM_FWD_EN defined: same-cycle same-address read/write returns forwarded data: lanes with wr_be set take wr_data, other lanes take stored data (write-first, per lane). Applies to both SYNC_READ modes.
- Not defined: read returns the stored (old) word (read-first); no bypass mux is synthesised.

## Structure
- Shared package ram_pkg: clear-state enum (CLR_IDLE, CLR_ACTIVE), helper function computing NB from WIDTH/BYTE_W, elaboration check that WIDTH % BYTE_W == 0.
- One sub-module: ram_clr_fsm (state, counter, clr_busy, zero-write address/strobe), reused by future multi-port RAMs.

## Test plan
- Reset release, DEPTH=64: clr_busy high 64 cycles then low; read every address → 0, rd_valid one cycle after each rd_en.
- Write 0xDEADBEEF_CAFEF00D to addr 5 with wr_be=0x0F over prior 0x11111111_11111111 → read addr 5 = 0x11111111_CAFEF00D.
- Same-cycle write 0xAA..AA (wr_be=0xFF) and read of addr 9 holding 0x55..55: with SDPRAM_FWD_EN → 0xAA..AA; without → 0x55..55; next read → 0xAA..AA.
- clr_req after filling array: writes/reads during the 64 busy cycles dropped (rd_valid 0); afterwards all words read 0; second clr_req at cycle 10 of clear does not extend clr_busy.
- DEPTH=48, SYNC_READ=0: write to addr 50 dropped; read addr 50 → 0 with rd_valid=1 combinationally; read addr 47 returns written value same cycle.
- Assert rst at clear cycle 20: rd_valid/rd_data 0 immediately, clear restarts and runs full 48/64 cycles.
